// File: rtl/nes_joypad_poller.sv
// -----------------------------------------------------------------------------
// nes_joypad_poller
//
// Host-side reader for a standard NES controller built around a 4021
// parallel-in/serial-out shift register. At a fixed poll rate the block
// latches the pad, clocks out all eight button bits, compares the new frame
// with the previous one and publishes the byte only when two consecutive
// frames agree. The published byte is active-high and is intended to be
// OR-merged with other button sources in the same clock domain.
//
// Parameters:
//   C_poll_div  clock cycles between poll starts (about 60 Hz at 21.477 MHz)
//   C_half      cycles per half-phase of the pad strobe/clock (>= 4)
//
// Ports:
//   clock       in   1  system clock
//   R_reset     in   1  synchronous, active-high reset
//   i_enable    in   1  0 = start no new frames (a running frame completes)
//   joy_data    in   1  pad serial data, active-low, asynchronous
//   joy_strobe  out  1  pad latch, active-high
//   joy_clock   out  1  pad shift clock, idles low, pad shifts on falling edge
//   o_buttons   out  8  stable buttons {right,left,down,up,start,select,b,a}
//   o_valid     out  1  one-cycle pulse whenever o_buttons is (re)loaded
//   o_busy      out  1  high whenever a frame is in progress
// -----------------------------------------------------------------------------
module nes_joypad_poller #(
  parameter int unsigned C_poll_div = 357954,
  parameter int unsigned C_half     = 64
) (
  input  logic       clock,
  input  logic       R_reset,
  input  logic       i_enable,
  input  logic       joy_data,
  output logic       joy_strobe,
  output logic       joy_clock,
  output logic [7:0] o_buttons,
  output logic       o_valid,
  output logic       o_busy
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (C_half < 4) begin : g_half_range
    $error("nes_joypad_poller: C_half must be at least 4");
  end

  // A whole frame (STROBE entry to DONE inclusive) must fit between polls.
  if ((17 * C_half + 1) >= C_poll_div) begin : g_frame_fits
    $error("nes_joypad_poller: 17*C_half+1 must be smaller than C_poll_div");
  end

  // ---------------------------------------------------------------------------
  // Widths and constants
  // ---------------------------------------------------------------------------
  localparam int unsigned C_PCW = (C_poll_div > 1) ? $clog2(C_poll_div) : 1;
  // The longest state (STROBE) lasts 2*C_half cycles.
  localparam int unsigned C_PHW = $clog2(2 * C_half);

  localparam logic [C_PCW-1:0] C_POLL_LAST   = C_PCW'(C_poll_div - 1);
  localparam logic [C_PHW-1:0] C_HALF_LAST   = C_PHW'(C_half - 1);
  localparam logic [C_PHW-1:0] C_STROBE_LAST = C_PHW'(2 * C_half - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STROBE = 3'd1,
    S_SETTLE = 3'd2,
    S_CLK_HI = 3'd3,
    S_CLK_LO = 3'd4,
    S_DONE   = 3'd5
  } t_state;

  // ---------------------------------------------------------------------------
  // Registers and wires
  // ---------------------------------------------------------------------------
  t_state             r_state;
  t_state             w_state_next;

  logic [C_PCW-1:0]   r_poll_cnt;
  logic [C_PHW-1:0]   r_phase;
  logic [2:0]         r_idx;
  logic [7:0]         r_raw;
  logic [7:0]         r_prev;
  logic               r_sync1;
  logic               r_sync2;

  logic               r_strobe;
  logic               r_clk;
  logic [7:0]         r_buttons;
  logic               r_valid;
  logic               r_busy;

  logic               w_poll_tick;
  logic               w_sample;
  logic               w_half_end;
  logic               w_strobe_end;
  logic [2:0]         w_idx_next;
  logic [7:0]         w_raw_next;
  logic [7:0]         w_prev_next;
  logic [7:0]         w_buttons_next;
  logic               w_valid_next;

  assign w_poll_tick  = (r_poll_cnt == C_POLL_LAST);
  // Pad data is active-low; invert so that a pressed button reads as 1.
  assign w_sample     = ~r_sync2;
  assign w_half_end   = (r_phase == C_HALF_LAST);
  assign w_strobe_end = (r_phase == C_STROBE_LAST);

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Two-flop synchronizer for the asynchronous pad data line (idles high).
  always_ff @(posedge clock) begin
    if (R_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= joy_data;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running poll divider; its terminal count is the poll tick.
  always_ff @(posedge clock) begin
    if (R_reset) begin
      r_poll_cnt <= '0;
    end else if (w_poll_tick) begin
      r_poll_cnt <= '0;
    end else begin
      r_poll_cnt <= r_poll_cnt + C_PCW'(1);
    end
  end

  // Phase counter: restarts at 0 on every state change, parked at 0 in IDLE.
  always_ff @(posedge clock) begin
    if (R_reset) begin
      r_phase <= '0;
    end else if ((w_state_next != r_state) || (r_state == S_IDLE)) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + C_PHW'(1);
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (R_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Frame datapath and registered outputs. The pad pins and o_busy are
  // decoded from the next state so that they line up with the state itself.
  always_ff @(posedge clock) begin
    if (R_reset) begin
      r_idx     <= 3'd0;
      r_raw     <= 8'h00;
      r_prev    <= 8'h00;
      r_strobe  <= 1'b0;
      r_clk     <= 1'b0;
      r_buttons <= 8'h00;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_idx     <= w_idx_next;
      r_raw     <= w_raw_next;
      r_prev    <= w_prev_next;
      r_strobe  <= (w_state_next == S_STROBE);
      r_clk     <= (w_state_next == S_CLK_HI);
      r_buttons <= w_buttons_next;
      r_valid   <= w_valid_next;
      r_busy    <= (w_state_next != S_IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath decode
  // ---------------------------------------------------------------------------

  // Frame sequencer: strobe, settle, then seven clock pulses with a sample
  // at the end of settle and at the end of every low half-phase.
  always_comb begin
    w_state_next   = r_state;
    w_idx_next     = r_idx;
    w_raw_next     = r_raw;
    w_prev_next    = r_prev;
    w_buttons_next = r_buttons;
    w_valid_next   = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Ticks that arrive while a frame is running are simply lost.
        if (w_poll_tick && i_enable) begin
          w_state_next = S_STROBE;
        end else begin
          w_state_next = S_IDLE;
        end
      end

      S_STROBE: begin
        if (w_strobe_end) begin
          w_state_next = S_SETTLE;
        end else begin
          w_state_next = S_STROBE;
        end
      end

      S_SETTLE: begin
        // After the latch the A button is already on the data line.
        if (w_half_end) begin
          w_raw_next[0] = w_sample;
          w_idx_next    = 3'd1;
          w_state_next  = S_CLK_HI;
        end else begin
          w_state_next  = S_SETTLE;
        end
      end

      S_CLK_HI: begin
        if (w_half_end) begin
          w_state_next = S_CLK_LO;
        end else begin
          w_state_next = S_CLK_HI;
        end
      end

      S_CLK_LO: begin
        // Sampling late in the low phase leaves room for the synchronizer.
        if (w_half_end) begin
          w_raw_next[r_idx] = w_sample;
          w_idx_next        = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_CLK_HI;
          end
        end else begin
          w_state_next = S_CLK_LO;
        end
      end

      S_DONE: begin
        // Two identical frames in a row are required before publishing;
        // the pulse repeats even when the published value is unchanged.
        if (r_raw == r_prev) begin
          w_buttons_next = r_raw;
          w_valid_next   = 1'b1;
        end else begin
          w_valid_next   = 1'b0;
        end
        w_prev_next  = r_raw;
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign joy_strobe = r_strobe;
  assign joy_clock  = r_clk;
  assign o_buttons  = r_buttons;
  assign o_valid    = r_valid;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_nes_joypad_poller.sv
// -----------------------------------------------------------------------------
// tb_nes_joypad_poller
//
// Directed bench for nes_joypad_poller with C_poll_div=200, C_half=4
// (69-cycle frame). A behavioural 4021 reloads on the strobe and shifts on
// the falling edge of joy_clock. A passive monitor accumulates edge and level
// counts; the directed sequence compares snapshot deltas against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_nes_joypad_poller;

  localparam int unsigned C_POLL = 200;
  localparam int unsigned C_HALF = 4;

  logic       clock    = 1'b0;
  logic       R_reset  = 1'b1;
  logic       i_enable = 1'b1;
  logic       joy_data;
  logic       joy_strobe;
  logic       joy_clock;
  logic [7:0] o_buttons;
  logic       o_valid;
  logic       o_busy;

  // Pad model state: buttons held (active-high) and the 4021 register.
  logic [7:0] pad_press = 8'h00;
  logic [7:0] pad_sr    = 8'hFF;

  int n_vec  = 0;
  int n_fail = 0;

  // Monitor accumulators.
  int   m_strobe_rise = 0;
  int   m_strobe_hi   = 0;
  int   m_clk_rise    = 0;
  int   m_clk_hi      = 0;
  int   m_busy_hi     = 0;
  int   m_valid_rise  = 0;
  int   m_valid_hi    = 0;
  int   m_bad_width   = 0;
  int   hi_run        = 0;
  int   lo_run        = 0;
  logic lo_ok         = 1'b0;
  logic p_strobe      = 1'b0;
  logic p_clk         = 1'b0;
  logic p_valid       = 1'b0;

  // Snapshots taken by the directed sequence.
  int s_strobe_rise, s_strobe_hi, s_clk_rise, s_clk_hi;
  int s_busy_hi, s_valid_rise, s_valid_hi, s_bad_width;

  nes_joypad_poller #(
    .C_poll_div(C_POLL),
    .C_half    (C_HALF)
  ) dut (
    .clock     (clock),
    .R_reset   (R_reset),
    .i_enable  (i_enable),
    .joy_data  (joy_data),
    .joy_strobe(joy_strobe),
    .joy_clock (joy_clock),
    .o_buttons (o_buttons),
    .o_valid   (o_valid),
    .o_busy    (o_busy)
  );

  always #5 clock = ~clock;

  assign joy_data = pad_sr[0];

  // Behavioural 4021: parallel load on strobe, shift toward Q8 on clock fall.
  always @(posedge joy_strobe or negedge joy_clock) begin
    if (joy_strobe) begin
      pad_sr <= ~pad_press;
    end else begin
      pad_sr <= {1'b1, pad_sr[7:1]};
    end
  end

  // Passive monitor sampled on the falling system-clock edge.
  always @(negedge clock) begin
    p_strobe <= joy_strobe;
    p_clk    <= joy_clock;
    p_valid  <= o_valid;
    if (joy_strobe && !p_strobe) m_strobe_rise <= m_strobe_rise + 1;
    if (joy_strobe)              m_strobe_hi   <= m_strobe_hi + 1;
    if (o_busy)                  m_busy_hi     <= m_busy_hi + 1;
    if (o_valid && !p_valid)     m_valid_rise  <= m_valid_rise + 1;
    if (o_valid)                 m_valid_hi    <= m_valid_hi + 1;
    if (joy_clock && !p_clk) begin
      m_clk_rise <= m_clk_rise + 1;
      if (lo_ok && (lo_run != 4)) m_bad_width <= m_bad_width + 1;
      hi_run <= 1;
      lo_ok  <= 1'b0;
    end else if (joy_clock) begin
      hi_run <= hi_run + 1;
    end else if (p_clk) begin
      if (hi_run != 4) m_bad_width <= m_bad_width + 1;
      lo_run <= 1;
      lo_ok  <= 1'b1;
    end else begin
      lo_run <= lo_run + 1;
      if (joy_strobe) lo_ok <= 1'b0;
    end
    if (joy_clock) m_clk_hi <= m_clk_hi + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_strobe_rise = m_strobe_rise;
    s_strobe_hi   = m_strobe_hi;
    s_clk_rise    = m_clk_rise;
    s_clk_hi      = m_clk_hi;
    s_busy_hi     = m_busy_hi;
    s_valid_rise  = m_valid_rise;
    s_valid_hi    = m_valid_hi;
    s_bad_width   = m_bad_width;
  endtask

  task automatic wait_busy();
    int n = 0;
    while (o_busy !== 1'b1 && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("busy_rise", 32'(o_busy), 32'd1);
  endtask

  // Waits for the frame to end, then one more edge so the monitor has
  // absorbed the o_valid cycle.
  task automatic wait_idle();
    int n = 0;
    while (o_busy !== 1'b0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("busy_fall", 32'(o_busy), 32'd0);
    @(negedge clock);
  endtask

  task automatic run_frame();
    wait_busy();
    wait_idle();
  endtask

  task automatic frame_chk(input logic [7:0] pad, input int exp_valid,
                           input logic [7:0] exp_btn, input string tag);
    pad_press = pad;
    snap();
    run_frame();
    chk({tag, "_valid"}, m_valid_rise - s_valid_rise, 32'(exp_valid));
    chk({tag, "_vwidth"}, m_valid_hi - s_valid_hi, 32'(exp_valid));
    chk({tag, "_btn"}, 32'(o_buttons), 32'(exp_btn));
  endtask

  task automatic count_to_strobe(input string tag);
    int n = 0;
    while (joy_strobe !== 1'b1 && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk(tag, 32'(n), 32'd200);
  endtask

  initial begin
    int n;
    int rises;
    logic pc;

    // ---- Reset and idle -----------------------------------------------------
    R_reset  = 1'b1;
    i_enable = 1'b1;
    repeat (5) @(negedge clock);
    chk("rst_strobe",  32'(joy_strobe), 32'd0);
    chk("rst_clock",   32'(joy_clock),  32'd0);
    chk("rst_buttons", 32'(o_buttons),  32'd0);
    chk("rst_valid",   32'(o_valid),    32'd0);
    chk("rst_busy",    32'(o_busy),     32'd0);
    snap();
    R_reset = 1'b0;
    count_to_strobe("first_strobe_cycle");
    wait_idle();
    chk("f0_strobe_rises", m_strobe_rise - s_strobe_rise, 32'd1);
    chk("f0_strobe_width", m_strobe_hi - s_strobe_hi, 32'd8);
    chk("f0_clk_pulses",   m_clk_rise - s_clk_rise, 32'd7);
    chk("f0_clk_hi_total", m_clk_hi - s_clk_hi, 32'd28);
    chk("f0_clk_widths",   m_bad_width - s_bad_width, 32'd0);
    // Empty pad matches the reset value of the previous-frame register.
    chk("f0_valid",        m_valid_rise - s_valid_rise, 32'd1);
    chk("f0_btn",          32'(o_buttons), 32'd0);

    // ---- Steady press {A, right} ---------------------------------------------
    frame_chk(8'h81, 0, 8'h00, "steady1");
    frame_chk(8'h81, 1, 8'h81, "steady2");
    frame_chk(8'h81, 1, 8'h81, "steady3");

    // ---- Glitch rejection ----------------------------------------------------
    frame_chk(8'h3C, 0, 8'h81, "glitch_sep");
    frame_chk(8'h81, 0, 8'h81, "glitch1");
    frame_chk(8'h81, 1, 8'h81, "glitch2");
    frame_chk(8'h01, 0, 8'h81, "glitch3");
    frame_chk(8'h81, 0, 8'h81, "glitch4");
    frame_chk(8'h81, 1, 8'h81, "glitch5");

    // ---- Enable gating -------------------------------------------------------
    i_enable = 1'b0;
    snap();
    repeat (1000) @(negedge clock);
    chk("dis_strobe_rises", m_strobe_rise - s_strobe_rise, 32'd0);
    chk("dis_busy_cycles",  m_busy_hi - s_busy_hi, 32'd0);

    i_enable = 1'b1;
    snap();
    wait_busy();
    n = 0;
    while (joy_clock !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("en_drop_in_clk_hi", 32'(joy_clock), 32'd1);
    i_enable = 1'b0;
    wait_idle();
    chk("en_drop_pulses", m_clk_rise - s_clk_rise, 32'd7);
    chk("en_drop_strobe", m_strobe_rise - s_strobe_rise, 32'd1);
    chk("en_drop_widths", m_bad_width - s_bad_width, 32'd0);
    chk("en_drop_valid",  m_valid_rise - s_valid_rise, 32'd1);
    chk("en_drop_btn",    32'(o_buttons), 32'h81);
    snap();
    repeat (300) @(negedge clock);
    chk("en_off_no_frame", m_strobe_rise - s_strobe_rise, 32'd0);
    i_enable = 1'b1;

    // ---- Reset in the third clock-high phase --------------------------------
    pad_press = 8'h81;
    snap();
    wait_busy();
    rises = 0;
    pc    = joy_clock;
    n     = 0;
    while (rises < 3 && n < 200) begin
      @(negedge clock);
      if (joy_clock && !pc) rises++;
      pc = joy_clock;
      n++;
    end
    chk("mid_rst_third_hi", 32'(rises), 32'd3);
    R_reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_clock",  32'(joy_clock),  32'd0);
    chk("mid_rst_strobe", 32'(joy_strobe), 32'd0);
    chk("mid_rst_busy",   32'(o_busy),     32'd0);
    chk("mid_rst_valid",  32'(o_valid),    32'd0);
    R_reset = 1'b0;
    count_to_strobe("mid_rst_restart");
    wait_idle();
    chk("mid_rst_no_valid", m_valid_rise - s_valid_rise, 32'd0);
    chk("mid_rst_btn",      32'(o_buttons), 32'd0);

    // ---- Bit-order walk ------------------------------------------------------
    for (int k = 0; k < 8; k++) begin
      pad_press = 8'h01 << k;
      run_frame();
      frame_chk(8'h01 << k, 1, 8'h01 << k, "walk");
    end

    // ---- Released / disconnected pad reads as nothing pressed ---------------
    pad_press = 8'h00;
    run_frame();
    frame_chk(8'h00, 1, 8'h00, "released");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/nes_joypad_poller.md
# nes_joypad_poller

Host-side reader for a standard NES controller (4021 parallel-in/serial-out shift register) on the `joy_strobe`/`joy_clock`/`joy_data` pins. It is the initiator end of the pad protocol, complementing the console-side pad responder. At a fixed poll rate it latches the pad, clocks out all 8 button bits, checks consecutive frames for agreement, and presents a stable active-high button byte. That byte is OR-merged with onboard and USB buttons in the NES clock domain.

## Interface
Parameters:
- `C_poll_div`, default 357954: clock cycles between poll starts (about 60 Hz at 21.477 MHz).
- `C_half`, default 64: cycles per half-phase of the pad strobe/clock; legal range ≥4.

Ports:
- `clock`  in  1: system clock (NES clock domain).
- `R_reset`  in  1: reset, synchronous, active-high; clock `clock`.
- `i_enable`  in  1: when 0, no new frames start; a frame already in progress completes.
- `joy_data`  in  1: pad serial data, active-low (0 = pressed); asynchronous.
- `joy_strobe`  out  1: pad latch, active-high.
- `joy_clock`  out  1: pad shift clock; idles low; pad shifts on the falling edge.
- `o_buttons`  out  8: stable buttons, active-high, ordered {right,left,down,up,start,select,b,a}, bit0 = A = first bit read.
- `o_valid`  out  1: one-cycle pulse when `o_buttons` is (re)loaded.
- `o_busy`  out  1: high in every state except IDLE.

## Operation
- `joy_data` passes through a 2-FF synchronizer. All sampling uses the synchronized value, inverted, so pressed = 1.
- Poll counter:
  - Free-running 0..C_poll_div-1, then wraps to 0.
  - Poll tick = (counter == C_poll_div-1).
  - A tick starts a frame only when state is IDLE and `i_enable` = 1. Ticks arriving in any other state are dropped.
- Phase counter counts 0..N-1 within each state and clears on every state change.
- Bit index: 3 bits. Raw shift register `raw[7:0]`. Previous-frame register `prev[7:0]`.
- State machine:
  - IDLE: strobe = 0, clock = 0. On a qualifying tick → STROBE.
  - STROBE: strobe = 1 for 2·C_half cycles → SETTLE.
  - SETTLE: strobe = 0 for C_half cycles. On the last cycle, `raw[0]` ← sample and bit index ← 1 → CLK_HI.
  - CLK_HI: clock = 1 for C_half cycles → CLK_LO.
  - CLK_LO: clock = 0 for C_half cycles. On the last cycle, `raw[idx]` ← sample and idx ← idx+1. If the sampled idx was 7 → DONE, else → CLK_HI.
  - DONE: one cycle.
    - If the new raw frame equals `prev`: `o_buttons` ← raw and `o_valid` = 1. The pulse occurs whether or not the value changed.
    - In all cases `prev` ← raw. Next state → IDLE.
- Result: exactly 7 clock pulses per frame, one strobe pulse, and 8 samples.
- Debounce rule: a value reaches `o_buttons` only after two consecutive identical frames. A single-frame glitch never propagates.

## Timing
- Frame length from STROBE entry to DONE inclusive: 17·C_half + 1 cycles. It must be < C_poll_div (checked by an elaboration assertion).
- First poll:
  - Poll tick occurs at cycle C_poll_div-1 after `R_reset` deasserts (cycle 0 = first cycle with reset low).
  - `joy_strobe` rises at cycle C_poll_div.
- Sample instants:
  - Bit 0: at cycle 3·C_half-1 after strobe rise.
  - Bit k: C_half-1 cycles after the k-th falling edge of `joy_clock`.
  - Synchronizer delay is 2 cycles, which is always inside the C_half settle window.
- `o_valid` and the new `o_buttons` appear in the cycle after DONE, registered outputs.
- Reset:
  - All outputs = 0, state = IDLE, poll counter = 0, `raw` = `prev` = 0, idx = 0.
  - Reset mid-frame drops `joy_strobe` and `joy_clock` low on the next edge. No `o_valid` is produced and the partial frame is discarded.
- `i_enable` falling mid-frame has no effect on the current frame.
- Disconnected pad (line pulled high) reads 0x00 and is treated as no buttons pressed.

## Test plan
Bench parameters: C_poll_div=200, C_half=4, giving a 69-cycle frame. The pad model is a behavioural 4021 that reloads while strobe = 1 and shifts on the falling edge of `joy_clock`.

- Reset and idle: hold `R_reset` 5 cycles, then release → all outputs 0; `joy_strobe` first rises at cycle 200; strobe high exactly 8 cycles; exactly 7 clock pulses, each 4 high / 4 low.
- Steady press, pad pressed = {A, right} (data low on bits 0 and 7):
  - Frame 1 → no `o_valid`.
  - Frame 2 → `o_buttons` = 0x81 with a 1-cycle `o_valid`.
  - Frame 3 → 0x81 and `o_valid` again.
- Glitch, sequence 0x81, 0x81, 0x01, 0x81, 0x81 → `o_buttons` stays 0x81 throughout; `o_valid` pulses after frames 2 and 5 only.
- Enable gating: `i_enable` = 0 for 1000 cycles → no strobe edges and `o_busy` = 0. Drop `i_enable` during CLK_HI → the frame still completes with 7 clocks.
- Reset mid-frame: assert `R_reset` during the 3rd CLK_HI → `joy_clock` = 0 next cycle, no `o_valid`, and the next strobe rises 200 cycles after release.
- Bit order walk: one button pressed at a time, bits 0..7, each held 2 frames → `o_buttons` = 1<<k for k = 0..7.
